// File: rtl/riscv_nn_int_controller_mc.sv
// Multi-line interrupt controller: per-line mask and level/edge mode, sticky edge pending,
// fixed-priority pick (lowest index wins) presented to the core controller via req/ack/kill.
//
// state   | meaning
// IDLE    | no request outstanding, arbitrating every cycle
// PENDING | request presented, id/sec frozen until ack or kill
// DONE    | acknowledged, one cycle gap before re-arbitration
module riscv_nn_int_controller_mc #(
   parameter int NUM_IRQ     = 32,
   parameter int ID_WIDTH    = 5,
   parameter bit PULP_SECURE = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_IRQ-1:0]  irq_i,
   input  logic [NUM_IRQ-1:0]  irq_sec_i,
   input  logic [NUM_IRQ-1:0]  irq_mask_i,
   input  logic [NUM_IRQ-1:0]  irq_edge_i,
   input  logic                m_IE_i,
   input  logic                u_IE_i,
   input  logic [1:0]          current_priv_lvl_i,
   input  logic                ctrl_ack_i,
   input  logic                ctrl_kill_i,
   output logic                irq_req_ctrl_o,
   output logic                irq_sec_ctrl_o,
   output logic [ID_WIDTH-1:0] irq_id_ctrl_o,
   output logic [NUM_IRQ-1:0]  irq_pending_o
);

   localparam logic [1:0] PRIV_LVL_U = 2'b00;
   localparam logic [1:0] PRIV_LVL_M = 2'b11;

   typedef enum logic [1:0] {IDLE, PENDING, DONE} state_t;

   state_t              state_q, state_d;
   logic [NUM_IRQ-1:0]  irq_q, pend_q, pend_d, raw, eff;
   logic [ID_WIDTH-1:0] id_q, win_id;
   logic                sec_q, win_sec, en, load, clr;

   assign raw = (irq_edge_i & pend_q) | (~irq_edge_i & irq_i);
   assign eff = raw & irq_mask_i;

   // Walk from the top down so the lowest set index is the last one assigned.
   always_comb begin
      win_id  = '0;
      win_sec = 1'b0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (eff[k]) begin
            win_id  = ID_WIDTH'(k);
            win_sec = irq_sec_i[k];
         end
      end
   end

   assign en = PULP_SECURE ?
               (((u_IE_i | win_sec) & (current_priv_lvl_i == PRIV_LVL_U)) |
                (m_IE_i & (current_priv_lvl_i == PRIV_LVL_M))) :
               m_IE_i;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      clr     = 1'b0;
      case (state_q)
         IDLE: begin
            if ((|eff) && en) begin
               state_d = PENDING;
               load    = 1'b1;
            end
         end
         PENDING: begin
            if (ctrl_ack_i) begin
               state_d = DONE;
               clr     = 1'b1;
            end else if (ctrl_kill_i) begin
               state_d = IDLE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A fresh rising edge wins over the ack-clear of the same line.
   always_comb begin
      pend_d = '0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         pend_d[k] = irq_edge_i[k] &
                     ((irq_i[k] & ~irq_q[k]) |
                      (pend_q[k] & ~(clr && (id_q == ID_WIDTH'(k)))));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         irq_q   <= '0;
         pend_q  <= '0;
         id_q    <= '0;
         sec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         irq_q   <= irq_i;
         pend_q  <= pend_d;
         if (load) begin
            id_q  <= win_id;
            sec_q <= win_sec;
         end else if (state_q == DONE) begin
            sec_q <= 1'b0;
         end
      end
   end

   assign irq_req_ctrl_o = (state_q == PENDING);
   assign irq_sec_ctrl_o = sec_q;
   assign irq_id_ctrl_o  = id_q;
   assign irq_pending_o  = raw;

endmodule

// File: tb/tb_riscv_nn_int_controller_mc.sv
// Randomized bench for riscv_nn_int_controller_mc: a non-secure and a secure instance share
// stimulus and are compared every cycle against a cycle-level behavioural model.
module tb_riscv_nn_int_controller_mc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] irq, irq_sec, irq_mask, irq_edge;
   logic        m_ie, u_ie, ack, kill;
   logic [1:0]  priv;

   logic        req0, req1, sec0, sec1;
   logic [4:0]  id0, id1;
   logic [31:0] pend0, pend1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   riscv_nn_int_controller_mc #(.NUM_IRQ(32), .ID_WIDTH(5), .PULP_SECURE(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_sec_i(irq_sec), .irq_mask_i(irq_mask),
      .irq_edge_i(irq_edge), .m_IE_i(m_ie), .u_IE_i(u_ie), .current_priv_lvl_i(priv),
      .ctrl_ack_i(ack), .ctrl_kill_i(kill), .irq_req_ctrl_o(req0), .irq_sec_ctrl_o(sec0),
      .irq_id_ctrl_o(id0), .irq_pending_o(pend0));

   riscv_nn_int_controller_mc #(.NUM_IRQ(32), .ID_WIDTH(5), .PULP_SECURE(1'b1)) dut_sec (
      .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_sec_i(irq_sec), .irq_mask_i(irq_mask),
      .irq_edge_i(irq_edge), .m_IE_i(m_ie), .u_IE_i(u_ie), .current_priv_lvl_i(priv),
      .ctrl_ack_i(ack), .ctrl_kill_i(kill), .irq_req_ctrl_o(req1), .irq_sec_ctrl_o(sec1),
      .irq_id_ctrl_o(id1), .irq_pending_o(pend1));

   // Model: per instance, the previous line levels, sticky edge flags, and which phase of
   // the handshake it is in (0 waiting, 1 request out, 2 post-ack gap).
   logic [31:0] m_prev [2];
   logic [31:0] m_pend [2];
   int          m_phase [2];
   int          m_id [2];
   bit          m_sec [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_raw(int s);
      logic [31:0] r;
      for (int k = 0; k < 32; k++) r[k] = irq_edge[k] ? m_pend[s][k] : irq[k];
      return r;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_prev[s] = '0; m_pend[s] = '0; m_phase[s] = 0; m_id[s] = 0; m_sec[s] = 0;
      end
   endtask

   task automatic model_step();
      for (int s = 0; s < 2; s++) begin
         logic [31:0] eff, np;
         int  win;
         bit  en;
         eff = m_raw(s) & irq_mask;
         win = -1;
         for (int i = 0; i < 32; i++) if (eff[i] && win < 0) win = i;
         if (s == 0) en = m_ie;
         else en = ((u_ie || (win >= 0 && irq_sec[win])) && priv == 2'b00) ||
                   (m_ie && priv == 2'b11);
         for (int k = 0; k < 32; k++) begin
            if (!irq_edge[k])                              np[k] = 1'b0;
            else if (irq[k] && !m_prev[s][k])              np[k] = 1'b1;
            else if (m_phase[s] == 1 && ack && m_id[s] == k) np[k] = 1'b0;
            else                                           np[k] = m_pend[s][k];
         end
         if (m_phase[s] == 0) begin
            if (win >= 0 && en) begin
               m_phase[s] = 1; m_id[s] = win; m_sec[s] = irq_sec[win];
            end
         end else if (m_phase[s] == 1) begin
            if (ack) m_phase[s] = 2;
            else if (kill) m_phase[s] = 0;
         end else begin
            m_phase[s] = 0; m_sec[s] = 0;
         end
         m_pend[s] = np;
         m_prev[s] = irq;
      end
   endtask

   task automatic check_outputs();
      chk("req0", {31'd0, req0}, {31'd0, m_phase[0] == 1});
      chk("id0", {27'd0, id0}, m_id[0]);
      chk("sec0", {31'd0, sec0}, {31'd0, m_sec[0]});
      chk("pend0", pend0, m_raw(0));
      chk("req1", {31'd0, req1}, {31'd0, m_phase[1] == 1});
      chk("id1", {27'd0, id1}, m_id[1]);
      chk("sec1", {31'd0, sec1}, {31'd0, m_sec[1]});
      chk("pend1", pend1, m_raw(1));
   endtask

   // Async reset pulse inside the low clock phase; irq is dropped so pending must read 0.
   task automatic pulse_reset();
      irq = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req0", {31'd0, req0}, 32'd0);
      chk("rst_id0", {27'd0, id0}, 32'd0);
      chk("rst_sec0", {31'd0, sec0}, 32'd0);
      chk("rst_pend0", pend0, 32'd0);
      chk("rst_req1", {31'd0, req1}, 32'd0);
      chk("rst_pend1", pend1, 32'd0);
      model_reset();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; irq = '0; irq_sec = '0; irq_mask = '0; irq_edge = '0;
      m_ie = 0; u_ie = 0; ack = 0; kill = 0; priv = 2'b11;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (cyc % 500 == 250) pulse_reset();
         if (cyc % 40 == 0) begin
            irq_edge = $urandom;
            irq_mask = ~($urandom & $urandom);
            irq_sec  = $urandom;
         end
         if (cyc % 7 == 0) begin
            case ($urandom_range(0, 3))
               0: priv = 2'b00;
               1: priv = 2'b01;
               default: priv = 2'b11;
            endcase
            u_ie = $urandom_range(0, 1);
         end
         // Line 0 kept rarer so higher indices also win arbitration.
         irq  = $urandom & $urandom & $urandom & 32'hFFFF_FFFE;
         if ($urandom_range(0, 15) == 0) irq[0] = 1'b1;
         m_ie = ($urandom_range(0, 3) != 0);
         ack  = ($urandom_range(0, 2) == 0);
         kill = ($urandom_range(0, 4) == 0);
         #1;
         check_outputs();
         @(posedge clk);
         model_step();
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/riscv_nn_int_controller_mc.md
Name: riscv_nn_int_controller_mc

Overview:
Multi-channel interrupt controller, next generation of the single-line core interrupt controller. Accepts NUM_IRQ independent interrupt lines. Each line has a per-line enable mask and a per-line level/edge mode. Edge-mode lines use sticky pending bits. A fixed-priority arbiter picks one line and presents it to the core controller through the existing req/ack/kill handshake; sits between the event unit and riscv_nn_controller.

Parameters:
NUM_IRQ, 32, number of interrupt lines (2..32)
ID_WIDTH, 5, width of interrupt id; must satisfy 2**ID_WIDTH >= NUM_IRQ
PULP_SECURE, 0, 1 enables U-mode/secure enable qualification

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
irq_i  in  NUM_IRQ  interrupt lines
irq_sec_i  in  NUM_IRQ  per-line secure bit
irq_mask_i  in  NUM_IRQ  per-line enable (1=enabled)
irq_edge_i  in  NUM_IRQ  per-line mode (1=rising-edge, 0=level)
m_IE_i  in  1  M-mode global interrupt enable
u_IE_i  in  1  U-mode global interrupt enable
current_priv_lvl_i  in  PrivLvl_t  current privilege level
ctrl_ack_i  in  1  controller accepted request
ctrl_kill_i  in  1  controller withdrew request
irq_req_ctrl_o  out  1  request to controller
irq_sec_ctrl_o  out  1  secure bit of latched request
irq_id_ctrl_o  out  ID_WIDTH  id of latched request
irq_pending_o  out  NUM_IRQ  raw pending vector, before masking

Behaviour:
- Reset: state IDLE. irq_q, pend_q, id_q, sec_q all 0. Outputs req=0, sec=0, id=0, pending=0 (irq_i low).
- Edge detect: irq_q <= irq_i every cycle. rise[k] = irq_i[k] & ~irq_q[k].
  - irq_q resets to 0, so a line already high at reset release registers as an edge.
- pend_q[k]: set on rise[k] when irq_edge_i[k]=1.
  - Cleared on the cycle ctrl_ack_i is accepted in PENDING for k=id_q.
  - Set beats clear when both happen in the same cycle (new edge not lost).
  - Forced 0 while irq_edge_i[k]=0.
- raw[k] = irq_edge_i[k] ? pend_q[k] : irq_i[k]. irq_pending_o = raw.
- eff = raw & irq_mask_i.
- Arbiter: lowest set index of eff wins (id 0 highest priority). Combinational; win_id zero-extended to ID_WIDTH.
- Global enable:
  - PULP_SECURE=1: en = ((u_IE_i | irq_sec_i[win]) & priv==PRIV_LVL_U) | (m_IE_i & priv==PRIV_LVL_M).
  - PULP_SECURE=0: en = m_IE_i.
- FSM:
  - IDLE: if |eff & en -> PENDING; id_q <= win_id; sec_q <= irq_sec_i[win].
  - PENDING: ctrl_ack_i -> DONE, and clear pend_q[id_q]. Else ctrl_kill_i -> IDLE; pend_q kept, so the line re-arbitrates. Else stay. Ack beats kill when both are high.
  - DONE: sec_q <= 0; -> IDLE unconditionally. id_q holds its last value.
- irq_req_ctrl_o = (state==PENDING). irq_sec_ctrl_o = sec_q. irq_id_ctrl_o = id_q.
- Once in PENDING, id/sec are frozen. Mask, enable or line deassertion do not retract the request; only ack/kill leave PENDING.
- Latency:
  - Level line high and enabled at cycle t -> req at t+1.
  - Edge line rises at t -> pend_q at t+1 -> req at t+2.
  - Minimum spacing between two acks is 3 cycles (PENDING, DONE, IDLE).
- Level line still high after DONE re-requests; software must clear the source.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous).

Test Plan:
- Level line 5 high, mask[5]=1, m_IE=1 -> req at next cycle, id=5. Ack -> DONE then IDLE, sec=0. Line still high -> req again 1 cycle after IDLE.
- Lines 3 (level) and 9 (edge) asserted the same cycle, all masked in -> id=3 first. After ack and line 3 dropped -> id=9. pend_q[9] clears on its ack.
- Edge line 7 pulses 1 cycle high with m_IE=0 -> pending_o[7]=1 and held, req=0. Set m_IE=1 -> req, id=7. Kill -> IDLE with pend_q[7] still 1 -> re-request.
- Ack and kill high together in PENDING -> DONE taken. Edge line 2 rises on its own ack cycle -> pend_q[2] remains 1.
- PULP_SECURE=1, priv=U, u_IE=0: line 4 with sec=1 -> req with sec_ctrl=1. Line 6 with sec=0 -> no req.
- Reset pulsed while in PENDING -> req=0, id=0, pending bits 0. An edge line held high at release -> req 2 cycles later.
